// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default geometry,
// the queue entry layout and a sizing helper for the occupancy counter.
package fetch_queue_pkg;

  localparam int unsigned   FQ_N        = 64;
  localparam int unsigned   FQ_DEPTH    = 4;
  localparam logic [63:0]   FQ_RESET_PC = 64'h0;

  // One queued fetch: the byte address it was fetched from and the word.
  typedef struct packed {
    logic [FQ_N-1:0] pc;
    logic [31:0]     word;
  } fetch_entry_t;

  // Occupancy must be able to represent DEPTH itself, hence the extra bit.
  function automatic int unsigned fq_count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched entries. Head data comes straight
// from the storage array, so outputs never depend combinationally on the
// write data. Flush empties the queue at the end of the cycle.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = FQ_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = fq_count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == CW'(0));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer / occupancy; a flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = CW'(0);
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= W'(0);
      end
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential word fetches, captures the
// one-cycle-latency memory response into a small queue and presents the
// head to decode. A redirect or reset discards everything queued or in flight.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned   N        = FQ_N,
  parameter int unsigned   DEPTH    = FQ_DEPTH,
  parameter logic [N-1:0]  RESET_PC = N'(FQ_RESET_PC)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          br_taken,
  input  logic [N-1:0]  br_target,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [N-1:0]  instr_pc
);

  localparam int unsigned CW = fq_count_width(DEPTH);

  // Same layout as fetch_entry_t, sized to this instance's address width.
  typedef struct packed {
    logic [N-1:0] pc;
    logic [31:0]  word;
  } entry_t;

  logic [N-1:0]  fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [N-1:0]  inflight_pc_q, inflight_pc_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW:0]   pending;
  logic          push;
  logic          pop;
  entry_t        push_entry;
  entry_t        head_entry;

  // Outstanding work counts both queued entries and the response in flight,
  // so a request is only made when its response is guaranteed a slot.
  assign pending  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign imem_req = !reset && !br_taken && (pending < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  // A response arriving in a redirect cycle belongs to the old path.
  assign push = inflight_q && !br_taken && !fifo_full;
  assign pop  = instr_valid && instr_ready;

  assign push_entry.pc   = inflight_pc_q;
  assign push_entry.word = imem_rdata;

  assign instr_valid = !fifo_empty;
  assign instr       = head_entry.word;
  assign instr_pc    = head_entry.pc;

  // Fetch PC / in-flight tracking: redirect wins over sequential advance.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (br_taken) begin
      fetch_pc_d    = br_target & ~N'(3);
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
    end else if (imem_req) begin
      fetch_pc_d    = fetch_pc_q + N'(4);
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end else begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
    end
  end

  // Fetch PC and in-flight request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= N'(0);
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (br_taken),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the fetch front end.
module tb_fetch_queue;

  localparam int unsigned  N        = 64;
  localparam int unsigned  DEPTH    = 4;
  localparam logic [63:0]  RESET_PC = 64'h0;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [63:0] br_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  fetch_queue #(.N(N), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } ent_t;

  int          n_checks;
  int          n_fail;

  // Reference model state
  logic [63:0] m_fpc;
  bit          m_infl;
  logic [63:0] m_ipc;
  ent_t        m_q[$];

  // Expected outputs for the current cycle
  bit          e_req;
  logic [63:0] e_addr;
  bit          e_valid;
  logic [63:0] e_pc;
  logic [31:0] e_word;

  // PCs of instructions the DUT actually handed to decode
  logic [63:0] obs_pc[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  // Apply this cycle's inputs (at negedge) and compute expected outputs.
  task automatic drive(input bit r, input bit br, input logic [63:0] tgt, input bit rdy);
    reset       = r;
    br_taken    = br;
    br_target   = tgt;
    instr_ready = rdy;
    imem_rdata  = m_infl ? mem_word(m_ipc) : 32'($urandom);
    #1;
    e_req   = !r && !br && ((m_q.size() + int'(m_infl)) < DEPTH);
    e_addr  = m_fpc;
    e_valid = (m_q.size() != 0);
    e_pc    = e_valid ? m_q[0].pc : 64'h0;
    e_word  = e_valid ? m_q[0].word : 32'h0;
  endtask

  // Advance the model by one clock and step the DUT to the next negedge.
  task automatic commit();
    if (instr_valid === 1'b1 && instr_ready === 1'b1) obs_pc.push_back(instr_pc);
    if (reset) begin
      m_q.delete();
      m_fpc  = RESET_PC;
      m_infl = 1'b0;
    end else begin
      if (e_valid && instr_ready) void'(m_q.pop_front());
      if (m_infl && !br_taken) m_q.push_back('{pc: m_ipc, word: mem_word(m_ipc)});
      if (br_taken) begin
        m_q.delete();
        m_fpc  = {br_target[63:2], 2'b00};
        m_infl = 1'b0;
      end else if (e_req) begin
        m_infl = 1'b1;
        m_ipc  = m_fpc;
        m_fpc  = m_fpc + 64'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    commit();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    commit();
    drive(1'b1, 1'b0, 64'h0, 1'b1);
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req); end
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    n_checks++;
    if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", instr); end
    n_checks++;
    if (instr_pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", instr_pc); end
    commit();
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'(4 * k)) begin
        n_fail++; $display("FAIL seq_req k=%0d got %b/%h exp 1/%h", k, imem_req, imem_addr, 64'(4 * k));
      end
      n_checks++;
      if (k >= 2) begin
        if (instr_valid !== 1'b1 || instr_pc !== 64'(4 * (k - 2)) || instr !== mem_word(64'(4 * (k - 2)))) begin
          n_fail++; $display("FAIL seq_head k=%0d got %b/%h/%h exp 1/%h", k, instr_valid, instr_pc, instr, 64'(4 * (k - 2)));
        end
      end else if (instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL seq_head k=%0d got valid %b exp 0", k, instr_valid);
      end
      commit();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] first_addr;
    bit          got;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b0);
      n_checks++;
      if (imem_req !== (k < 4)) begin
        n_fail++; $display("FAIL bp_req k=%0d got %b exp %b", k, imem_req, (k < 4));
      end
      if (k < 4) begin
        n_checks++;
        if (imem_addr !== 64'(4 * k)) begin n_fail++; $display("FAIL bp_addr k=%0d got %h exp %h", k, imem_addr, 64'(4 * k)); end
      end
      if (k >= 2) begin
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h0) begin
          n_fail++; $display("FAIL bp_hold k=%0d got %b/%h exp 1/0", k, instr_valid, instr_pc);
        end
      end
      commit();
    end
    obs_pc.delete();
    got = 1'b0;
    first_addr = 64'hX;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      if (imem_req === 1'b1 && !got) begin got = 1'b1; first_addr = imem_addr; end
      commit();
    end
    n_checks++;
    if (obs_pc.size() < 4) begin
      n_fail++; $display("FAIL bp_drain got %0d deliveries exp >=4", obs_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_pc[i] !== 64'(4 * i)) begin n_fail++; $display("FAIL bp_order i=%0d got %h exp %h", i, obs_pc[i], 64'(4 * i)); end
      end
    end
    n_checks++;
    if (first_addr !== 64'h10) begin n_fail++; $display("FAIL bp_resume got %h exp 10", first_addr); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b0);
      commit();
    end
    drive(1'b0, 1'b1, 64'h43, 1'b0);
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL br_req got %b exp 0", imem_req); end
    commit();
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h40) begin
      n_fail++; $display("FAIL br_next got %b/%b/%h exp 0/1/40", instr_valid, imem_req, imem_addr);
    end
    commit();
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    n_checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 64'h44) begin
      n_fail++; $display("FAIL br_drop got %b/%h exp 0/44", instr_valid, imem_addr);
    end
    commit();
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 64'h40 || instr !== mem_word(64'h40)) begin
      n_fail++; $display("FAIL br_target got %b/%h/%h exp 1/40", instr_valid, instr_pc, instr);
    end
    commit();
  endtask

  task automatic test_redirect_transfer();
    int n8, nc;
    do_reset();
    obs_pc.delete();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      commit();
    end
    drive(1'b0, 1'b1, 64'h100, 1'b1);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 64'h8) begin
      n_fail++; $display("FAIL brx_head got %b/%h exp 1/8", instr_valid, instr_pc);
    end
    commit();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      commit();
    end
    n8 = 0;
    nc = 0;
    foreach (obs_pc[i]) begin
      if (obs_pc[i] === 64'h8) n8++;
      if (obs_pc[i] === 64'hC) nc++;
    end
    n_checks++;
    if (n8 != 1 || nc != 0) begin n_fail++; $display("FAIL brx_count got n8=%0d nC=%0d exp 1/0", n8, nc); end
    n_checks++;
    if (obs_pc.size() < 4 || obs_pc[3] !== 64'h100) begin
      n_fail++; $display("FAIL brx_next got size %0d exp 4th pc 100", obs_pc.size());
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b0);
      commit();
    end
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req got %b exp 0", imem_req); end
    commit();
    obs_pc.delete();
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL rst_mid_first got %b/%b/%h exp 0/1/%h", instr_valid, imem_req, imem_addr, RESET_PC);
    end
    commit();
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale got valid %b exp 0", instr_valid); end
    commit();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      commit();
    end
    n_checks++;
    if (obs_pc.size() != 6) begin n_fail++; $display("FAIL rst_mid_count got %0d exp 6", obs_pc.size()); end
    foreach (obs_pc[i]) begin
      n_checks++;
      if (obs_pc[i] !== RESET_PC + 64'(4 * i)) begin
        n_fail++; $display("FAIL rst_mid_order i=%0d got %h exp %h", i, obs_pc[i], RESET_PC + 64'(4 * i));
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_seq [4];
    exp_seq[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    exp_seq[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_seq[2] = 64'h0;
    exp_seq[3] = 64'h4;
    do_reset();
    obs_pc.delete();
    drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
    commit();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      if (k < 4) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_seq[k]) begin
          n_fail++; $display("FAIL wrap_addr k=%0d got %b/%h exp 1/%h", k, imem_req, imem_addr, exp_seq[k]);
        end
      end
      commit();
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_pc.size() <= i || obs_pc[i] !== exp_seq[i]) begin
        n_fail++; $display("FAIL wrap_deliver i=%0d got %h exp %h", i, (obs_pc.size() > i) ? obs_pc[i] : 64'hX, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    bit          r, br, rdy;
    logic [63:0] tgt;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      r   = ($urandom_range(0, 99) == 0);
      br  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
      drive(r, br, tgt, rdy);
      n_checks++;
      if (imem_req !== e_req) begin n_fail++; $display("FAIL rnd_req k=%0d got %b exp %b", k, imem_req, e_req); end
      if (e_req) begin
        n_checks++;
        if (imem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr k=%0d got %h exp %h", k, imem_addr, e_addr); end
      end
      n_checks++;
      if (instr_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid k=%0d got %b exp %b", k, instr_valid, e_valid); end
      if (e_valid) begin
        n_checks++;
        if (instr_pc !== e_pc || instr !== e_word) begin
          n_fail++; $display("FAIL rnd_head k=%0d got %h/%h exp %h/%h", k, instr_pc, instr, e_pc, e_word);
        end
      end
      commit();
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    br_taken    = 1'b0;
    br_target   = 64'h0;
    instr_ready = 1'b0;
    imem_rdata  = 32'h0;
    m_fpc       = RESET_PC;
    m_infl      = 1'b0;
    m_ipc       = 64'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_transfer();
    test_reset_midway();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be (name, default, meaning): N, 64, PC/address width; DEPTH, 4, queue entries (power of two, >=2); RESET_PC, 0, first fetch address.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  instruction-memory read request this cycle
- imem_addr  out  N  byte address of request, bits[1:0]=00
- imem_rdata  in  32  instruction word, valid exactly one cycle after an accepted request
- br_taken  in  1  redirect strobe from execute
- br_target  in  N  redirect byte address
- instr_valid  out  1  head entry available
- instr_ready  in  1  decode stage accepts head
- instr  out  32  head instruction word (decode uses instr[31:21])
- instr_pc  out  N  byte address of head instruction
REQ-003 Clock and reset SHALL be the only clock/reset: one clock, reset synchronous and active-high.

Function
REQ-004 Block SHALL fetch sequentially from an internal fetch PC, incrementing by 4 per issued request, modulo 2^N.
REQ-005 imem_req SHALL assert iff (occupancy + in-flight) < DEPTH and br_taken is low and reset is low; imem_addr SHALL equal fetch PC.
REQ-006 imem_rdata returned in cycle t+1 for a request in cycle t SHALL be enqueued at the end of t+1 with its request PC; at most one request in flight.
REQ-007 Queue SHALL be FIFO; instr, instr_pc SHALL come from registered head storage (no imem_rdata-to-output combinational path).
REQ-008 instr_valid SHALL equal (occupancy != 0); transfer occurs on a cycle with instr_valid && instr_ready and removes the head.
REQ-009 instr, instr_pc SHALL hold stable while instr_valid && !instr_ready.
REQ-010 Simultaneous enqueue and dequeue SHALL leave occupancy unchanged; enqueue into a full queue SHALL not occur (guaranteed by REQ-005).
REQ-011 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL be a log2(DEPTH)+1-bit counter.
REQ-012 On br_taken: fetch PC SHALL load {br_target[N-1:2],2'b00}; all queue entries SHALL be discarded at end of cycle; an in-flight response returning the next cycle SHALL be dropped; first request to target SHALL issue the following cycle.
REQ-013 A head transfer coincident with br_taken SHALL complete (entry counts as delivered), then the flush applies.
REQ-014 br_taken on consecutive cycles: last target SHALL win.
REQ-015 Latency: first request to a PC in cycle t -> instr_valid with that PC in cycle t+2 when queue empty.
REQ-016 Steady state with instr_ready held high SHALL sustain one instruction per cycle after initial latency.

Reset
REQ-017 While reset is high: fetch PC=RESET_PC, occupancy=0, pointers=0, in-flight flag=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-018 Reset asserted mid-operation SHALL discard queue and any in-flight response; first request after release SHALL be RESET_PC in the first cycle reset is low.

Structure
REQ-019 Shared package SHALL hold N, DEPTH, RESET_PC defaults and typedef fetch_entry_t {pc[N-1:0], word[31:0]}.
REQ-020 Storage SHALL be a sub-module fetch_fifo (sync reset, flush input, push/pop, full/empty, occupancy); PC, in-flight and redirect logic stay in fetch_queue.

Verification
REQ-021 Reset release, instr_ready=1, imem returns word = addr: req addrs 0,4,8 in cycles 0,1,2; instr_valid from cycle 2 with instr_pc 0,4,8 one per cycle.
REQ-022 Backpressure: instr_ready=0 from start -> exactly 4 requests (0..C), imem_req low afterwards, head stays pc=0 stable; raise ready -> 0,4,8,C delivered in order, fetching resumes at 0x10.
REQ-023 Redirect br_taken=1, br_target=0x43 with 2 entries queued and one in flight -> next cycle instr_valid=0, in-flight word dropped, req addr 0x40; instr_pc 0x40 appears 2 cycles after request.
REQ-024 Redirect coincident with head transfer (pc 0x8) -> 0x8 counted delivered once, no later delivery of 0xC.
REQ-025 Reset asserted for 1 cycle with 3 entries and a request in flight -> instr_valid=0, next req addr=RESET_PC, no stale word ever delivered.
REQ-026 Fetch PC at 2^N-4 -> next request addr 0, delivered instr_pc sequence ...FFFC, 0.
